// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types for the data-memory arbiter.
//   - size codes driven on *_size / mem_size
//   - arbiter FSM state encoding
//   - requester id type (0 = pipeline MEM stage, 1 = debug/DMA loader)
//   - is_aligned(): natural-alignment check for a size code and the low address bits
package dm_arb_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic id_t;

    // Size code 2'b11 falls into the default arm and is checked as a word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return ~addr_lo[0];
            SZ_BYTE: return 1'b1;
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational winner select between the two requesters.
//   req[1:0]     in   request lines, bit n = port n
//   last_winner  in   id of the most recent grant (only with DM_ARB_RR_EN)
//   valid        out  at least one request is pending
//   winner       out  id of the port to grant
// Build option DM_ARB_RR_EN: when defined, contention goes to the port that did
// not win last; when undefined, port 0 always beats port 1.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef DM_ARB_RR_EN
    input  logic       last_winner,
`endif
    output logic       valid,
    output id_t        winner
);

    // NOTE: every output of a combinational block gets a value on every path
    // (here via the unconditional assignments), otherwise a latch is inferred.
    always_comb begin
        valid = |req;
`ifdef DM_ARB_RR_EN
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else begin
            winner = ~req[0];
        end
`else
        winner = ~req[0];
`endif
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between port 0 (pipeline MEM
// stage) and port 1 (debug/DMA loader). Each transaction takes three cycles:
// grant (IDLE), memory access (ISSUE), response pulse (RESP).
//   clk, reset            clock; synchronous active-high reset
//   m*_req/we/size/addr/wdata/pc   request fields, held until granted
//   m*_gnt                one-cycle accept pulse
//   m*_rvalid / m*_err    completion pulse; err marks a misaligned, unperformed access
//   m*_rdata              per-port load result, held until that port's next load
//   mem_*                 command to the memory; mem_rdata is its combinational read data
// Build option DM_ARB_RR_EN: round-robin on contention (else port 0 has fixed priority).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [31:0]       m0_pc,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [31:0]       m1_pc,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_we,
    output logic              mem_re,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_next;

    logic              cmd_we;
    logic [1:0]        cmd_size;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [31:0]       cmd_pc;
    id_t               cmd_id;

    logic              pick_valid;
    id_t               pick_id;
    logic              grant;
    logic              aligned;
    logic              resp;

`ifdef DM_ARB_RR_EN
    logic              last_winner;
`endif

    dm_arb_pick u_pick (
        .req         ({m1_req, m0_req}),
`ifdef DM_ARB_RR_EN
        .last_winner (last_winner),
`endif
        .valid       (pick_valid),
        .winner      (pick_id)
    );

    // Grants are only given from IDLE; requests seen in ISSUE/RESP simply wait.
    assign grant  = (state == IDLE) & pick_valid & ~reset;
    assign m0_gnt = grant & (pick_id == 1'b0);
    assign m1_gnt = grant & (pick_id == 1'b1);

    assign aligned = is_aligned(cmd_size, cmd_addr[1:0]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Command registers feed mem_* directly, so they are reset to give a quiet
    // bus (all zero) straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_we    <= 1'b0;
            cmd_size  <= SZ_WORD;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_pc    <= '0;
            cmd_id    <= 1'b0;
        end else if (grant) begin
            cmd_we    <= pick_id ? m1_we    : m0_we;
            cmd_size  <= pick_id ? m1_size  : m0_size;
            cmd_addr  <= pick_id ? m1_addr  : m0_addr;
            cmd_wdata <= pick_id ? m1_wdata : m0_wdata;
            cmd_pc    <= pick_id ? m1_pc    : m0_pc;
            cmd_id    <= pick_id;
        end
    end

`ifdef DM_ARB_RR_EN
    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset)      last_winner <= 1'b1;
        else if (grant) last_winner <= pick_id;
    end
`endif

    // Memory command. A write is blocked in a reset cycle so an interrupted
    // store never lands in memory.
    assign mem_we    = (state == ISSUE) & cmd_we & aligned & ~reset;
    assign mem_re    = (state == ISSUE) & ~cmd_we & aligned;
    assign mem_size  = cmd_size;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign mem_pc    = cmd_pc;

    // Per-port load result registers: the read data is captured at the end of
    // ISSUE so it is already valid during the RESP pulse. A misaligned load
    // returns zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if ((state == ISSUE) && !cmd_we) begin
            if (cmd_id == 1'b0) m0_rdata <= aligned ? mem_rdata : '0;
            else                m1_rdata <= aligned ? mem_rdata : '0;
        end
    end

    // A reset in RESP drops the completion.
    assign resp      = (state == RESP) & ~reset;
    assign m0_rvalid = resp & (cmd_id == 1'b0);
    assign m1_rvalid = resp & (cmd_id == 1'b1);
    assign m0_err    = m0_rvalid & ~aligned;
    assign m1_err    = m1_rvalid & ~aligned;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory between two requesters: port 0, the pipeline MEM stage, and port 1, a debug/DMA loader. Each request is latched, issued to the memory for exactly one cycle, and answered with a one-cycle response pulse. Every transaction is 3 cycles long. The block sits between the requesters and the data memory; the memory keeps its combinational read and posedge write.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed at 32, other values unsupported

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  request valid; held stable with all fields until granted
- m0_we / m1_we  in  1  1 = store, 0 = load
- m0_size / m1_size  in  2  00 word, 01 half, 10 byte; 11 is treated as word
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  store data, right-aligned
- m0_pc / m1_pc  in  32  PC tag forwarded to the memory for the write trace
- m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted this cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle completion pulse, for loads and stores
- m0_err / m1_err  out  1  qualifies rvalid: access was misaligned and not performed
- m0_rdata / m1_rdata  out  DATA_W  load result; valid with rvalid; held afterwards
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read strobe
- mem_size  out  2  size code driven to the memory
- mem_addr  out  ADDR_W  address driven to the memory
- mem_wdata  out  DATA_W  write data driven to the memory
- mem_pc  out  32  PC tag driven to the memory
- mem_rdata  in  DATA_W  combinational, sign-extended read result from the memory

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE → ISSUE when m0_req | m1_req.
  - gnt is combinational: (state==IDLE) & winner.
  - The winner's we/size/addr/wdata/pc and its id are latched into command registers.
- ISSUE → RESP, unconditionally.
  - mem_* are driven from the command registers.
  - mem_we = cmd_we & aligned & !reset.
  - mem_re = !cmd_we & aligned.
  - On a load, mem_rdata is captured into a response register at the clock edge.
- RESP → IDLE, unconditionally.
  - rvalid pulses on the latched id only.
  - err = !aligned; rdata = 0 when err is set.
- Alignment rules:
  - word needs addr[1:0]==0.
  - half needs addr[0]==0.
  - byte is always aligned.
- Misaligned access: no memory strobe is raised; the completion still occurs, with err=1.
- Winner selection when both requesters are asserted: the port other than last_winner. last_winner updates on each grant.
- A single requester always wins.
- Requests arriving in ISSUE or RESP wait; they are not queued and not granted until IDLE.
- m0_rdata and m1_rdata are separate hold registers. Each updates only on its own load completion.

## Timing
- Grant at cycle T, memory access at T+1, rvalid at T+2, next grant no earlier than T+3.
- Peak throughput: 1 access per 3 cycles.
- Reset values:
  - state = IDLE, last_winner = 1 (so m0 wins the first contention).
  - All gnt/rvalid/err outputs = 0.
  - rdata = 0.
  - mem_we = 0, mem_re = 0.
  - Command registers = 0, so mem_addr, mem_wdata, mem_pc and mem_size are 0.
- Reset mid-transaction:
  - The in-flight access is dropped; no rvalid is produced.
  - mem_we is suppressed in the reset cycle.
  - Requesters must re-request.
- Requester dropping req before grant: the request is legally withdrawn; no side effects.

## Configuration
- DM_ARB_RR_EN defined: round-robin selection as described above.
- DM_ARB_RR_EN undefined: fixed priority, m0 always beats m1.
  - last_winner logic is compiled out.
  - All other behaviour is identical.

## Structure
- Package dm_arb_pkg:
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - FSM state enum: IDLE, ISSUE, RESP.
  - Requester id type, 1 bit.
- Sub-module dm_arb_pick: combinational winner select from req[1:0] and last_winner, honouring DM_ARB_RR_EN.

## Test plan
- m0 word store, addr 0x10, wdata 0xDEADBEEF → gnt0 at T; mem_we=1 with addr 0x10 at T+1; rvalid0=1, err0=0 at T+2.
- m1 byte load from 0x13, memory returns 0xFFFFFF80 → m1_rdata = 0xFFFFFF80 at T+2; m0_rdata unchanged.
- Both requesters asserted continuously with DM_ARB_RR_EN → grants alternate m0, m1, m0, m1, one every 3 cycles. Without the macro → m0 only.
- m0 half load at 0x21 → no mem_re; rvalid0=1, err0=1, m0_rdata=0 at T+2.
- reset asserted during ISSUE of a store → mem_we=0 that cycle, no rvalid, state IDLE next cycle.
- m1 requests during RESP of an m0 transaction → gnt1 occurs the cycle after RESP, not before.
